// File: rtl/quick_queue_host.sv
// quick_queue_host: host-side initiator for the head node of a QuickQueue
// systolic chain. It turns client enqueue/dequeue/clear requests into
// single-cycle chain commands, spaces them by the chain's settle time,
// captures dequeued minimums and tracks occupancy.
module quick_queue_host #(
  parameter int W                  = 32,
  parameter int DEPTH              = 16,
  parameter int CNT_W              = 8,
  parameter int SETTLE_CYC         = 2,
  parameter int READ_LAT           = 2,
  parameter int RST_CYC            = 2,
  parameter logic [W-1:0] EMPTY_VAL = {W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n_i,
  input  logic             enq_valid_i,
  input  logic [W-1:0]     enq_data_i,
  output logic             enq_ready_o,
  input  logic             deq_valid_i,
  output logic             deq_ready_o,
  output logic [W-1:0]     deq_data_o,
  output logic             deq_data_valid_o,
  input  logic             clear_i,
  output logic [W-1:0]     data_lt_o,
  output logic             write_o,
  output logic             read_o,
  output logic             reset_o,
  input  logic [W-1:0]     data_lt_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             busy_o,
  output logic             chain_err_o
);

  // The occupancy counter must be able to represent a full chain, and every
  // timing phase must last at least one cycle.
  if (DEPTH > (2 ** CNT_W) - 1) begin : g_depth_chk
    $error("quick_queue_host: DEPTH does not fit in CNT_W bits");
  end
  if (SETTLE_CYC < 1 || READ_LAT < 1 || RST_CYC < 1 ||
      SETTLE_CYC > 256 || READ_LAT > 256 || RST_CYC > 256) begin : g_timing_chk
    $error("quick_queue_host: timing parameters must be within 1..256");
  end

  typedef enum logic [2:0] {
    IDLE,
    ENQ,
    DEQ,
    DEQ_WAIT,
    SETTLE,
    CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [7:0]       SETTLE_L = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]       READ_L   = 8'(READ_LAT - 1);
  localparam logic [7:0]       RST_L    = 8'(RST_CYC - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Status flags and the client handshakes; clear beats dequeue beats enqueue.
  assign full_o      = (count_o == DEPTH_C);
  assign empty_o     = (count_o == '0);
  assign busy_o      = (state != IDLE);
  assign deq_ready_o = (state == IDLE) && !empty_o && !clear_i;
  assign enq_ready_o = (state == IDLE) && !full_o && !clear_i &&
                       !(deq_valid_i && !empty_o);

  // Command sequencer: issues one registered chain command per accepted
  // request, waits out read latency and reset hold, then the settle gap.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      write_o          <= 1'b0;
      read_o           <= 1'b0;
      reset_o          <= 1'b0;
      data_lt_o        <= '0;
      deq_data_o       <= '0;
      deq_data_valid_o <= 1'b0;
      count_o          <= '0;
      chain_err_o      <= 1'b0;
    end else begin
      write_o          <= 1'b0;
      read_o           <= 1'b0;
      deq_data_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_i) begin
            state    <= CLEAR;
            reset_o  <= 1'b1;
            count_o  <= '0;
            wait_cnt <= RST_L;
          end else if (deq_valid_i && deq_ready_o) begin
            state   <= DEQ;
            read_o  <= 1'b1;
            count_o <= count_o - ONE_C;
          end else if (enq_valid_i && enq_ready_o) begin
            state     <= ENQ;
            write_o   <= 1'b1;
            data_lt_o <= enq_data_i;
            count_o   <= count_o + ONE_C;
          end
        end
        ENQ: begin
          state    <= SETTLE;
          wait_cnt <= SETTLE_L;
        end
        DEQ: begin
          state    <= DEQ_WAIT;
          wait_cnt <= READ_L;
        end
        DEQ_WAIT: begin
          if (wait_cnt == 8'd0) begin
            deq_data_o       <= data_lt_i;
            deq_data_valid_o <= 1'b1;
            if (data_lt_i == EMPTY_VAL) begin
              chain_err_o <= 1'b1;
            end
            state    <= SETTLE;
            wait_cnt <= SETTLE_L;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        SETTLE: begin
          if (wait_cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        CLEAR: begin
          if (wait_cnt == 8'd0) begin
            reset_o  <= 1'b0;
            state    <= SETTLE;
            wait_cnt <= SETTLE_L;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_queue_host.sv
// tb_quick_queue_host: self-checking bench for quick_queue_host. A min-priority
// chain model answers the host's commands; expected results come from a
// bench-side queue of what the client asked for.
module tb_quick_queue_host;

  localparam logic [31:0] EMPTY_VAL = 32'hFFFF_FFFF;
  localparam int OP_ENQ = 0;
  localparam int OP_DEQ = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enq_valid, deq_valid, clear;
  logic [31:0] enq_data;
  logic        enq_ready, deq_ready, deq_data_valid;
  logic [31:0] deq_data, data_lt_out, data_lt_in;
  logic        write_cmd, read_cmd, reset_cmd;
  logic [7:0]  count;
  logic        full, empty, busy, chain_err;

  // Second, small-capacity instance for the full-chain corner case.
  logic        s_enq_valid;
  logic [31:0] s_enq_data;
  logic        s_enq_ready, s_deq_ready, s_deq_data_valid;
  logic [31:0] s_deq_data, s_data_lt_out;
  logic        s_write, s_read, s_reset;
  logic [7:0]  s_count;
  logic        s_full, s_empty, s_busy, s_chain_err;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_write_cyc = 0;
  bit chain_fault = 1'b0;

  logic [31:0] chain_q[$];
  logic [31:0] exp_q[$];

  quick_queue_host dut (
    .clk(clk), .reset_n_i(reset_n),
    .enq_valid_i(enq_valid), .enq_data_i(enq_data), .enq_ready_o(enq_ready),
    .deq_valid_i(deq_valid), .deq_ready_o(deq_ready),
    .deq_data_o(deq_data), .deq_data_valid_o(deq_data_valid),
    .clear_i(clear), .data_lt_o(data_lt_out),
    .write_o(write_cmd), .read_o(read_cmd), .reset_o(reset_cmd),
    .data_lt_i(data_lt_in), .count_o(count), .full_o(full), .empty_o(empty),
    .busy_o(busy), .chain_err_o(chain_err)
  );

  quick_queue_host #(.DEPTH(4)) dut_small (
    .clk(clk), .reset_n_i(reset_n),
    .enq_valid_i(s_enq_valid), .enq_data_i(s_enq_data), .enq_ready_o(s_enq_ready),
    .deq_valid_i(1'b0), .deq_ready_o(s_deq_ready),
    .deq_data_o(s_deq_data), .deq_data_valid_o(s_deq_data_valid),
    .clear_i(1'b0), .data_lt_o(s_data_lt_out),
    .write_o(s_write), .read_o(s_read), .reset_o(s_reset),
    .data_lt_i(EMPTY_VAL), .count_o(s_count), .full_o(s_full), .empty_o(s_empty),
    .busy_o(s_busy), .chain_err_o(s_chain_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int min_idx(input logic [31:0] q[$]);
    int m = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] < q[m]) m = i;
    return m;
  endfunction

  // Chain model: a min-priority store that answers a read with its minimum.
  always @(negedge clk) begin
    if (!reset_n || reset_cmd) begin
      chain_q.delete();
    end else if (write_cmd) begin
      chain_q.push_back(data_lt_out);
    end else if (read_cmd) begin
      if (chain_q.size() == 0) begin
        data_lt_in = EMPTY_VAL;
      end else begin
        int m;
        m = min_idx(chain_q);
        data_lt_in = chain_fault ? EMPTY_VAL : chain_q[m];
        chain_q.delete(m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act_v,
                             input logic [63:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) checkOutput("idle_timeout", busy, 0);
  endtask

  task automatic doEnq(input logic [31:0] value);
    bit ok = 0;
    enq_valid = 1'b1;
    enq_data  = value;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (enq_ready) begin ok = 1; break; end
      tick();
    end
    checkOutput("enq_accept", ok, 1);
    if (!ok) begin enq_valid = 1'b0; return; end
    tick();
    enq_valid = 1'b0;
    enq_data  = $urandom;
    checkOutput("write_pulse", write_cmd, 1);
    checkOutput("write_data", data_lt_out, value);
    last_write_cyc = cyc;
    tick();
    checkOutput("write_one_cycle", write_cmd, 0);
    checkOutput("data_lt_hold", data_lt_out, value);
  endtask

  task automatic doDeq(input logic [31:0] exp_data);
    bit ok = 0;
    int hs;
    int got = -100;
    deq_valid = 1'b1;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (deq_ready) begin ok = 1; break; end
      tick();
    end
    checkOutput("deq_accept", ok, 1);
    if (!ok) begin deq_valid = 1'b0; return; end
    tick();
    deq_valid = 1'b0;
    hs = cyc;
    checkOutput("read_pulse", {read_cmd, write_cmd, reset_cmd}, 3'b100);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (deq_data_valid) begin got = cyc; break; end
    end
    checkOutput("deq_latency", got - hs, 3);
    checkOutput("deq_data", deq_data, exp_data);
    tick();
    checkOutput("deq_valid_one_cycle", deq_data_valid, 0);
  endtask

  task automatic doClear();
    waitIdle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear_reset_c1", {reset_cmd, count, empty}, {1'b1, 8'd0, 1'b1});
    tick();
    checkOutput("clear_reset_c2", reset_cmd, 1);
    tick();
    checkOutput("clear_reset_c3", reset_cmd, 0);
  endtask

  // One client operation against the expected-contents model.
  task automatic applyStimulus(input int op, input logic [31:0] value);
    if (op == OP_ENQ) begin
      exp_q.push_back(value);
      doEnq(value);
    end else begin
      int m;
      m = min_idx(exp_q);
      doDeq(exp_q[m]);
      exp_q.delete(m);
    end
    checkOutput("count", count, exp_q.size());
  endtask

  typedef struct {
    int          op;
    logic [31:0] value;
    logic [31:0] exp_data;
    int          exp_count;
    bit          check_gap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int prev_write;
    int writes;
    vecs[0] = '{OP_ENQ, 32'd5, 32'd0, 1, 1'b0};
    vecs[1] = '{OP_ENQ, 32'd3, 32'd0, 2, 1'b1};
    vecs[2] = '{OP_ENQ, 32'd9, 32'd0, 3, 1'b1};
    vecs[3] = '{OP_DEQ, 32'd0, 32'd3, 2, 1'b0};
    vecs[4] = '{OP_DEQ, 32'd0, 32'd5, 1, 1'b0};
    vecs[5] = '{OP_DEQ, 32'd0, 32'd9, 0, 1'b0};

    reset_n = 1'b0; enq_valid = 0; deq_valid = 0; clear = 0;
    enq_data = 0; data_lt_in = 0; s_enq_valid = 0; s_enq_data = 0;
    tick(); tick();
    checkOutput("reset_cmds", {write_cmd, read_cmd, reset_cmd, deq_data_valid}, 4'b0);
    checkOutput("reset_data", {data_lt_out, deq_data}, 64'd0);
    checkOutput("reset_status", {count, empty, full, busy, chain_err}, {8'd0, 4'b1000});
    reset_n = 1'b1;
    tick();
    enq_valid = 1'b1;
    #1;
    checkOutput("enq_ready_after_reset", {enq_ready, deq_ready}, 2'b10);
    enq_valid = 1'b0;

    // Small chain: fill to capacity, then a held request must be refused.
    s_enq_valid = 1'b1;
    writes = 0;
    for (int n = 0; n < 40; n++) begin
      s_enq_data = $urandom;
      tick();
      if (s_write) writes++;
    end
    checkOutput("small_fill_writes", writes, 4);
    checkOutput("small_full", {s_count, s_full, s_enq_ready}, {8'd4, 2'b10});
    writes = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (s_write) writes++;
    end
    checkOutput("small_no_write", writes, 0);
    checkOutput("small_count_hold", s_count, 4);
    s_enq_valid = 1'b0;

    // Table: enqueue 5, 3, 9 then drain in priority order.
    prev_write = 0;
    foreach (vecs[i]) begin
      if (vecs[i].op == OP_ENQ) begin
        doEnq(vecs[i].value);
        if (vecs[i].check_gap) checkOutput("enq_spacing", last_write_cyc - prev_write, 4);
        prev_write = last_write_cyc;
      end else begin
        doDeq(vecs[i].exp_data);
      end
      checkOutput("table_count", count, vecs[i].exp_count);
    end
    checkOutput("table_empty", empty, 1);

    // Simultaneous enqueue and dequeue: dequeue wins, enqueue follows.
    doEnq(32'd10);
    doEnq(32'd20);
    waitIdle();
    enq_valid = 1'b1; enq_data = 32'd77; deq_valid = 1'b1;
    #1;
    checkOutput("both_ready", {deq_ready, enq_ready}, 2'b10);
    tick();
    deq_valid = 1'b0;
    prev_write = cyc;
    checkOutput("both_read_first", {read_cmd, write_cmd, count}, {2'b10, 8'd1});
    writes = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (write_cmd) begin writes = cyc; break; end
    end
    enq_valid = 1'b0;
    checkOutput("both_enq_after", writes - prev_write, 6);
    checkOutput("both_enq_data", data_lt_out, 77);
    checkOutput("both_count", count, 2);

    // Clear in SETTLE is dropped; clear in IDLE resets the chain.
    doEnq(32'd30);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    writes = 0;
    for (int n = 0; n < 6; n++) begin
      if (reset_cmd) writes++;
      tick();
    end
    checkOutput("clear_ignored", writes, 0);
    checkOutput("clear_ignored_count", count, 3);
    doClear();

    // Reset during DEQ_WAIT aborts the dequeue without a result.
    doEnq(32'd42);
    waitIdle();
    deq_valid = 1'b1;
    tick();
    deq_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_outputs", {write_cmd, read_cmd, reset_cmd, deq_data_valid, busy, empty},
                6'b000001);
    checkOutput("midreset_count", count, 0);
    tick();
    reset_n = 1'b1;
    writes = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (deq_data_valid || busy) writes++;
    end
    checkOutput("midreset_no_result", writes, 0);

    // Chain returns the empty sentinel while occupied: sticky error.
    chain_fault = 1'b1;
    doEnq(32'd55);
    doDeq(EMPTY_VAL);
    checkOutput("chain_err_set", chain_err, 1);
    chain_fault = 1'b0;
    doEnq(32'd8);
    doDeq(32'd8);
    checkOutput("chain_err_sticky", chain_err, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("chain_err_cleared", chain_err, 0);

    // Random client traffic against the expected-contents model.
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        doClear();
        exp_q.delete();
        checkOutput("rand_clear_count", count, 0);
      end else if ((r < 5 && exp_q.size() > 0) || exp_q.size() == 16) begin
        applyStimulus(OP_DEQ, 32'd0);
      end else begin
        applyStimulus(OP_ENQ, $urandom & 32'h7FFF_FFFF);
      end
    end
    checkOutput("rand_no_err", chain_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quick_queue_host.md
Name: quick_queue_host

Overview:
- Host-side initiator that drives the left-hand interface of the first QuickQueue node in the systolic chain.
- Converts client enqueue/dequeue requests (valid/ready) into single-cycle write_o/read_o commands with data on data_lt_o.
- Captures the minimum value the chain returns on data_lt_i.
- Tracks occupancy (count/full/empty) and issues chain resets.

Parameters:
- W, 32, data width (matches node data_lt/data_rt width)
- DEPTH, 16, total chain capacity in entries
- CNT_W, 8, occupancy counter width; elaboration error if DEPTH > 2^CNT_W - 1
- SETTLE_CYC, 2, idle cycles the chain needs after any command before the next
- READ_LAT, 2, cycles from read_o high to valid data_lt_i
- RST_CYC, 2, cycles reset_o is held high on clear
- EMPTY_VAL, 32'hFFFFFFFF, sentinel the chain returns when empty

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- enq_valid_i  in  1  client enqueue request
- enq_data_i  in  W  value to enqueue
- enq_ready_o  out  1  enqueue accepted when high with enq_valid_i
- deq_valid_i  in  1  client dequeue request
- deq_ready_o  out  1  dequeue accepted when high with deq_valid_i
- deq_data_o  out  W  dequeued value (held until next result)
- deq_data_valid_o  out  1  one-cycle pulse, deq_data_o valid
- clear_i  in  1  request chain-wide clear
- data_lt_o  out  W  data to node 0 left input
- write_o  out  1  enqueue command to node 0
- read_o  out  1  dequeue command to node 0
- reset_o  out  1  reset command to chain
- data_lt_i  in  W  value returned from node 0
- count_o  out  CNT_W  current occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- busy_o  out  1  state != IDLE
- chain_err_o  out  1  sticky: returned EMPTY_VAL while count > 0

Behaviour:
- Reset (reset_n_i low, async):
  - state=IDLE; all command outputs, deq_data_o, data_lt_o, count_o and chain_err_o are 0.
  - empty_o=1.
  - Any in-flight operation is aborted with no deq_data_valid_o pulse.
- All chain-side outputs (write_o, read_o, reset_o, data_lt_o) are registered.
- States: IDLE, ENQ, DEQ, DEQ_WAIT, SETTLE, CLEAR.
- IDLE priority is clear_i > dequeue > enqueue:
  - deq_ready_o = IDLE & !empty_o & !clear_i
  - enq_ready_o = IDLE & !full_o & !clear_i & !(deq_valid_i & !empty_o)
- Enqueue handshake at cycle 0:
  - Data is registered.
  - Cycle 1: state ENQ; write_o=1 for exactly one cycle; data_lt_o=data; count increments at the same edge.
  - Then SETTLE for SETTLE_CYC cycles, then IDLE. Next accept is possible at cycle 2+SETTLE_CYC.
- Dequeue handshake at cycle 0:
  - Cycle 1: read_o=1 for one cycle; count decrements at the same edge.
  - DEQ_WAIT counts READ_LAT cycles, then data_lt_i is sampled.
  - Cycle 2+READ_LAT: deq_data_valid_o=1 with deq_data_o=sample.
  - Then SETTLE, then IDLE.
  - If the sample equals EMPTY_VAL, chain_err_o is set; it is cleared only by reset_n_i low.
- clear_i is sampled only in IDLE; it is ignored (not queued) in other states.
  - Cycle 1: state CLEAR; reset_o=1 for RST_CYC cycles; count=0.
  - Then SETTLE, then IDLE.
- data_lt_o holds its last value when write_o=0.
- write_o, read_o and reset_o are mutually exclusive: at most one is high in any cycle.
- Counter arithmetic is unsigned CNT_W bits. It never over- or underflows, because the ready gating prevents it.
- Client inputs are don't-care outside a handshake; enq_data_i is sampled only on the handshake cycle.

Test Plan:
1. Assert reset_n_i low mid-simulation -> all outputs 0, empty_o=1, count_o=0; release -> enq_ready_o=1 while enq_valid_i=1.
2. With a min-priority chain model, enqueue 5, 3, 9:
   - Each produces a 1-cycle write_o with data_lt_o=5/3/9, spaced 4 cycles apart; count_o=3.
   - Then 3 dequeues -> deq_data_o=3, 5, 9, each at handshake+4; empty_o=1.
3. Override DEPTH=4 and enqueue 4 values -> full_o=1 and enq_ready_o=0; a 5th enq_valid_i held 20 cycles -> no write_o, count_o stays 4.
4. count_o=2, enq_valid_i and deq_valid_i asserted together -> dequeue accepted first (read_o); enqueue accepted on return to IDLE; final count_o=2.
5. Assert clear_i during SETTLE -> ignored. Assert clear_i in IDLE with count_o=3 -> reset_o high exactly 2 cycles, count_o=0, empty_o=1.
6. Two fault cases:
   - Pull reset_n_i low during DEQ_WAIT -> no deq_data_valid_o, state IDLE.
   - Separately, chain model returns 32'hFFFFFFFF with count_o=1 -> chain_err_o=1, and it stays 1 through later operations.
